// File: rtl/cordic_rot_gain_comp.sv
// CORDIC gain compensation: scales x/y by 1/K with rounding and saturation,
// then buffers results in a small non-stalling output FIFO.
module cordic_rot_gain_comp #(
    parameter int unsigned data_width = 16,
    parameter int unsigned gain_q     = 19898,
    parameter int unsigned fifo_depth = 4
) (
    input  logic                          clk,
    input  logic                          nreset,
    input  logic                          enable,
    input  logic signed [data_width-1:0]  x_vec_in,
    input  logic signed [data_width-1:0]  y_vec_in,
    input  logic                          in_valid,
    output logic signed [data_width-1:0]  x_vec_out,
    output logic signed [data_width-1:0]  y_vec_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(fifo_depth):0]   fifo_count,
    output logic                          sat_flag,
    output logic                          overflow,
    input  logic                          flags_clr
);

    localparam int unsigned W  = data_width;
    localparam int unsigned PW = 2 * W + 1;
    localparam int unsigned SW = PW + 1;
    localparam int unsigned AW = $clog2(fifo_depth);
    localparam int unsigned CW = AW + 1;

    localparam logic signed [PW-1:0] GAIN = PW'(gain_q);
    localparam logic signed [SW-1:0] RND  = {{(SW-W+1){1'b0}}, 1'b1, {(W-2){1'b0}}};
    localparam logic signed [SW-1:0] MAXV = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};

    // Round half-up, drop the Q fraction and clip; MSB of the result is the clip indicator.
    function automatic logic [W:0] f_round_sat(input logic signed [PW-1:0] p);
        logic signed [SW-1:0] v;
        logic [W:0]           res;
        v   = (SW'(p) + RND) >>> (W - 1);
        res = {1'b0, v[W-1:0]};
        if (v > MAXV) begin
            res = {1'b1, MAXV[W-1:0]};
        end else if (v < MINV) begin
            res = {1'b1, MINV[W-1:0]};
        end
        return res;
    endfunction

    logic                 w_capture;
    logic signed [PW-1:0] w_px, w_py;
    logic [W:0]           w_rx, w_ry;

    logic                 r_s1_valid;
    logic signed [PW-1:0] r_s1_px, r_s1_py;
    logic                 r_s2_valid, r_s2_sat;
    logic [W-1:0]         r_s2_x, r_s2_y;

    logic [W-1:0]  r_mem_x [fifo_depth];
    logic [W-1:0]  r_mem_y [fifo_depth];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [W-1:0]  r_head_x, r_head_y;
    logic          r_out_valid, r_sat, r_ovf;

    logic          w_pop, w_full, w_push, w_drop;
    logic [AW-1:0] w_rd_next;
    logic [CW-1:0] w_count_next;
    logic [W-1:0]  w_head_x, w_head_y;

    assign w_capture = in_valid & enable;
    assign w_px      = PW'(x_vec_in) * GAIN;
    assign w_py      = PW'(y_vec_in) * GAIN;
    assign w_rx      = f_round_sat(r_s1_px);
    assign w_ry      = f_round_sat(r_s1_py);

    // Stage 1: capture and full-precision multiply.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_s1_valid <= 1'b0;
            r_s1_px    <= '0;
            r_s1_py    <= '0;
        end else begin
            r_s1_valid <= w_capture;
            if (w_capture) begin
                r_s1_px <= w_px;
                r_s1_py <= w_py;
            end
        end
    end

    // Stage 2: rounded, shifted and saturated result.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_s2_valid <= 1'b0;
            r_s2_sat   <= 1'b0;
            r_s2_x     <= '0;
            r_s2_y     <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_x   <= w_rx[W-1:0];
                r_s2_y   <= w_ry[W-1:0];
                r_s2_sat <= w_rx[W] | w_ry[W];
            end
        end
    end

    assign w_pop     = (r_count != '0) && out_ready;
    assign w_full    = (r_count == CW'(fifo_depth));
    assign w_push    = r_s2_valid && (!w_full || w_pop);
    assign w_drop    = r_s2_valid && w_full && !w_pop;
    assign w_rd_next = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;

    // Next occupancy and next head entry (bypass when the push lands at the head slot).
    always_comb begin
        w_count_next = r_count;
        w_head_x     = '0;
        w_head_y     = '0;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CW'(1);
        end
        if (w_count_next != '0) begin
            if (w_push && (r_wr_ptr == w_rd_next)) begin
                w_head_x = r_s2_x;
                w_head_y = r_s2_y;
            end else begin
                w_head_x = r_mem_x[w_rd_next];
                w_head_y = r_mem_y[w_rd_next];
            end
        end
    end

    // FIFO storage, pointers, registered head and sticky flags.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < int'(fifo_depth); i++) begin
                r_mem_x[i] <= '0;
                r_mem_y[i] <= '0;
            end
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_head_x    <= '0;
            r_head_y    <= '0;
            r_out_valid <= 1'b0;
            r_sat       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem_x[r_wr_ptr] <= r_s2_x;
                r_mem_y[r_wr_ptr] <= r_s2_y;
                r_wr_ptr          <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr    <= w_rd_next;
            r_count     <= w_count_next;
            r_head_x    <= w_head_x;
            r_head_y    <= w_head_y;
            r_out_valid <= (w_count_next != '0);
            if (r_s2_valid && r_s2_sat) begin
                r_sat <= 1'b1;
            end else if (flags_clr) begin
                r_sat <= 1'b0;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (flags_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign x_vec_out  = r_head_x;
    assign y_vec_out  = r_head_y;
    assign out_valid  = r_out_valid;
    assign fifo_count = r_count;
    assign sat_flag   = r_sat;
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_cordic_rot_gain_comp.sv
// Self-checking bench: queue-based reference model of the gain stage and FIFO.
module tb_cordic_rot_gain_comp;

    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int GAIN  = 19898;
    localparam int GAIN2 = 65535;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                nreset, enable, in_valid, out_ready, flags_clr;
    logic signed [W-1:0] x_in, y_in;
    logic signed [W-1:0] x_out, y_out, x_out2, y_out2;
    logic                o_valid, sat, ovf, o_valid2, sat2, ovf2;
    logic [2:0]          count, count2;
    logic                ready2;

    cordic_rot_gain_comp #(.data_width(W), .gain_q(GAIN), .fifo_depth(DEPTH)) dut (
        .clk(clk), .nreset(nreset), .enable(enable),
        .x_vec_in(x_in), .y_vec_in(y_in), .in_valid(in_valid),
        .x_vec_out(x_out), .y_vec_out(y_out), .out_valid(o_valid), .out_ready(out_ready),
        .fifo_count(count), .sat_flag(sat), .overflow(ovf), .flags_clr(flags_clr)
    );

    cordic_rot_gain_comp #(.data_width(W), .gain_q(GAIN2), .fifo_depth(DEPTH)) dut_sat (
        .clk(clk), .nreset(nreset), .enable(enable),
        .x_vec_in(x_in), .y_vec_in(y_in), .in_valid(in_valid),
        .x_vec_out(x_out2), .y_vec_out(y_out2), .out_valid(o_valid2), .out_ready(ready2),
        .fifo_count(count2), .sat_flag(sat2), .overflow(ovf2), .flags_clr(flags_clr)
    );

    typedef struct { int x; int y; } smp_t;
    typedef struct { longint due; int x; int y; bit s; } pend_t;

    smp_t   m_fifo[$];
    pend_t  m_pend[$];
    bit     m_sat, m_ovf;
    longint cyc;
    int     n_tests, n_fail;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: round(v * g / 2^15) with half-up rounding, clipped to 16-bit signed.
    function automatic int scale(input int v, input int g, output bit s);
        longint r;
        r = (longint'(v) * longint'(g) + 64'sd16384) >>> 15;
        s = 1'b0;
        if (r > 32767) begin r = 32767; s = 1'b1; end
        else if (r < -32768) begin r = -32768; s = 1'b1; end
        return int'(r);
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        m_pend.delete();
        m_sat = 1'b0;
        m_ovf = 1'b0;
    endtask

    // One clock edge of the reference, using the inputs present at that edge.
    task automatic model_edge();
        bit    pop, set_sat, set_ovf, sx, sy;
        pend_t p;
        smp_t  e;
        pop     = (m_fifo.size() != 0) && out_ready;
        set_sat = 1'b0;
        set_ovf = 1'b0;
        if (pop) void'(m_fifo.pop_front());
        if (m_pend.size() != 0 && m_pend[0].due == cyc) begin
            p = m_pend.pop_front();
            if (p.s) set_sat = 1'b1;
            if (m_fifo.size() < DEPTH) begin
                e.x = p.x; e.y = p.y;
                m_fifo.push_back(e);
            end else begin
                set_ovf = 1'b1;
            end
        end
        if (set_sat) m_sat = 1'b1; else if (flags_clr) m_sat = 1'b0;
        if (set_ovf) m_ovf = 1'b1; else if (flags_clr) m_ovf = 1'b0;
        if (enable && in_valid) begin
            p.due = cyc + 2;
            p.x   = scale(int'(x_in), GAIN, sx);
            p.y   = scale(int'(y_in), GAIN, sy);
            p.s   = sx | sy;
            m_pend.push_back(p);
        end
        cyc++;
    endtask

    task automatic compare_all();
        bit ne;
        ne = (m_fifo.size() != 0);
        check("out_valid", longint'(o_valid), longint'(ne));
        check("x_out", longint'(x_out), ne ? longint'(m_fifo[0].x) : 0);
        check("y_out", longint'(y_out), ne ? longint'(m_fifo[0].y) : 0);
        check("count", longint'(count), longint'(m_fifo.size()));
        check("sat_flag", longint'(sat), longint'(m_sat));
        check("overflow", longint'(ovf), longint'(m_ovf));
    endtask

    // Advance one clock and compare all outputs 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        if (nreset) model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        flags_clr = 1'b0;
        enable    = 1'b1;
    endtask

    task automatic drain();
        idle_inputs();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        for (int i = 0; i < 12 && o_valid; i++) step();
        check("drain_timeout", longint'(o_valid), 0);
        flags_clr = 1'b1;
        step();
        flags_clr = 1'b0;
    endtask

    task automatic one_sample(input int xv, input int yv, input int ex, input int ey);
        x_in = 16'(xv); y_in = 16'(yv); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("lat_early", longint'(o_valid), 0);
        step();
        check("lat_valid", longint'(o_valid), 1);
        check("gain_x", longint'(x_out), longint'(ex));
        check("gain_y", longint'(y_out), longint'(ey));
    endtask

    int exp_ord[4];
    int saved;

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0;
        ready2 = 1'b1;
        model_reset();
        nreset = 1'b0; out_ready = 1'b0; x_in = '0; y_in = '0;
        idle_inputs();
        step(); step();
        check("rst_valid2", longint'(o_valid2), 0);
        #2 nreset = 1'b1;

        // Gain and rounding.
        drain();
        one_sample(361, 0, 219, 0);
        one_sample(256, -256, 155, -155);
        one_sample(0, 256, 0, 155);

        // Saturation on the high-gain instance.
        drain();
        x_in = 16'(32767); y_in = 16'(-32768); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        check("sat2_valid", longint'(o_valid2), 1);
        check("sat2_x", longint'(x_out2), 32767);
        check("sat2_y", longint'(y_out2), -32768);
        check("sat2_flag", longint'(sat2), 1);
        check("sat2_ovf", longint'(ovf2), 0);
        flags_clr = 1'b1;
        step();
        flags_clr = 1'b0;
        check("sat2_clr", longint'(sat2), 0);
        check("sat2_count", longint'(count2), 0);

        // Overflow: six samples into a stalled FIFO.
        drain();
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            x_in = 16'(i); y_in = '0; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        step(); step();
        check("ovf_count", longint'(count), 4);
        check("ovf_flag", longint'(ovf), 1);
        exp_ord[0] = 1; exp_ord[1] = 1; exp_ord[2] = 2; exp_ord[3] = 2;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ovf_order", longint'(x_out), longint'(exp_ord[i]));
            step();
        end
        check("ovf_empty", longint'(o_valid), 0);

        // Full FIFO with a push and pop on the same edge.
        drain();
        for (int i = 0; i < 7; i++) begin
            x_in = 16'(1000 * (i + 1)); y_in = 16'(-500 * (i + 1));
            in_valid  = (i < 5);
            out_ready = (i == 6);
            step();
        end
        out_ready = 1'b0; in_valid = 1'b0;
        check("full_pop_count", longint'(count), 4);
        check("full_pop_ovf", longint'(ovf), 0);
        check("full_pop_head", longint'(x_out), longint'(scale(2000, GAIN, saved[0])));

        // Enable gating.
        drain();
        out_ready = 1'b0;
        saved = int'(count);
        enable = 1'b0; in_valid = 1'b1; x_in = 16'(777); y_in = 16'(-777);
        for (int i = 0; i < 3; i++) step();
        step(); step();
        check("gate_count", longint'(count), longint'(saved));
        enable = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("gate_lat1", longint'(count), longint'(saved));
        step();
        check("gate_lat2", longint'(count), longint'(saved + 1));

        // Reset mid-stream with three buffered entries.
        drain();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            x_in = 16'(5000 + i); y_in = 16'(3000 - i); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        step(); step();
        check("pre_rst_count", longint'(count), 3);
        #2 nreset = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("rst_count2", longint'(count2), 0);
        step();
        #2 nreset = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Randomized traffic with phases of varying back-pressure.
        for (int i = 0; i < 600; i++) begin
            x_in      = 16'($urandom);
            y_in      = 16'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            enable    = ($urandom_range(0, 7) != 0);
            flags_clr = ($urandom_range(0, 24) == 0);
            case ((i / 50) % 3)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = ($urandom_range(0, 3) == 0);
                default: out_ready = $urandom_range(0, 1) != 0;
            endcase
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
